uart_top: RTL and testbench

Full-duplex 8N1 UART endpoint: one transmitter and one receiver sharing a single clock domain, fixed baud set by `CLKS_PER_BIT`. It sits between the board-level serial pins and on-chip logic. Parallel bytes are loaded through a one-cycle valid strobe and serialized onto `o_uart_txd`. Serial frames on `i_uart_rxd` are deserialized onto `o_rx_byte`. Two status outputs are intended to drive LEDs.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx.sv | 102 ++++++++++
 rtl/uart_tx.sv | 98 +++++++++
 rtl/uart_top.sv | 53 +++++
 tb/tb_uart_top.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the 8N1 UART slice.
//   - tx_state_e / rx_state_e : FSM state encodings
//   - DEFAULT_CLKS_PER_BIT    : 100 MHz / 115200 baud
//   - DATA_BITS / FRAME_BITS  : 8N1 frame geometry
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned FRAME_BITS           = DATA_BITS + 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_CLEANUP
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 deserializer with 2-flop input synchronizer.
//   i_clk, i_rst_n (sync, active-low)
//   i_rx_serial : asynchronous serial line, idles high
//   o_rx_byte   : last well-framed byte, held until the next good frame
//   o_rx_dv     : set on a good frame, cleared at the next start-bit edge
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_serial,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_dv
);

  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  rx_state_e     state;
  logic          rx_meta;
  logic          rx_sync;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx_serial;
      rx_sync <= rx_meta;
    end
  end

  // The edge-detect cycle in IDLE counts as the first cycle of the
  // half-bit wait, hence the counter is preloaded with 1 there.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= RX_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      o_rx_byte <= '0;
      o_rx_dv   <= 1'b0;
    end else begin
      unique case (state)
        RX_IDLE: begin
          clk_cnt <= CW'(1);
          bit_idx <= '0;
          if (!rx_sync) begin
            o_rx_dv <= 1'b0;
            state   <= RX_START;
          end
        end
        RX_START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (clk_cnt == CNT_MAX) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (clk_cnt == CNT_MAX) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              o_rx_byte <= shift;
              o_rx_dv   <= 1'b1;
            end
            state <= RX_CLEANUP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_CLEANUP: begin
          state <= RX_IDLE;
        end
        default: begin
          state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer.
//   i_clk, i_rst_n (sync, active-low)
//   i_tx_dv/i_tx_byte : one-cycle load strobe and byte, honoured only in IDLE
//   o_tx_done         : one-cycle pulse after the stop bit
//   o_tx_active       : high while start/data/stop bits are on the line
//   o_tx_serial       : serial line, idles high
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_done,
  output logic       o_tx_active,
  output logic       o_tx_serial
);

  localparam int unsigned   CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    data;

  // Line level is registered together with the state change, so each bit's
  // level is already on the pin during the first cycle of that bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= TX_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      data        <= '0;
      o_tx_done   <= 1'b0;
      o_tx_active <= 1'b0;
      o_tx_serial <= 1'b1;
    end else begin
      o_tx_done <= 1'b0;
      unique case (state)
        TX_IDLE: begin
          clk_cnt     <= '0;
          bit_idx     <= '0;
          o_tx_serial <= 1'b1;
          o_tx_active <= 1'b0;
          if (i_tx_dv) begin
            data        <= i_tx_byte;
            o_tx_serial <= 1'b0;
            o_tx_active <= 1'b1;
            state       <= TX_START;
          end
        end
        TX_START: begin
          if (clk_cnt == CNT_MAX) begin
            clk_cnt     <= '0;
            o_tx_serial <= data[0];
            state       <= TX_DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (clk_cnt == CNT_MAX) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_tx_serial <= 1'b1;
              state       <= TX_STOP;
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              o_tx_serial <= data[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (clk_cnt == CNT_MAX) begin
            clk_cnt     <= '0;
            o_tx_done   <= 1'b1;
            o_tx_active <= 1'b0;
            state       <= TX_DONE;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        TX_DONE: begin
          state <= TX_IDLE;
        end
        default: begin
          state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_top.sv
// uart_top: full-duplex 8N1 UART endpoint, one clock domain.
//   i_clk, i_rst_n (sync, active-low)
//   i_uart_rxd / o_uart_txd   : board serial pins (idle high)
//   i_tx_dv, i_tx_byte        : transmit load strobe and byte
//   o_tx_done                 : one-cycle pulse at end of stop bit
//   o_rx_byte                 : last well-framed received byte
//   o_rx_dv_led, o_tx_active_led : status LEDs
module uart_top
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rxd,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_done,
  output logic [7:0] o_rx_byte,
  output logic       o_uart_txd,
  output logic       o_rx_dv_led,
  output logic       o_tx_active_led
);

  logic tx_active;
  logic rx_dv;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_tx_dv    (i_tx_dv),
    .i_tx_byte  (i_tx_byte),
    .o_tx_done  (o_tx_done),
    .o_tx_active(tx_active),
    .o_tx_serial(o_uart_txd)
  );

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx_serial(i_uart_rxd),
    .o_rx_byte  (o_rx_byte),
    .o_rx_dv    (rx_dv)
  );

  assign o_tx_active_led = tx_active;
  assign o_rx_dv_led     = rx_dv;

endmodule

// File: tb/tb_uart_top.sv
`timescale 1ns/1ps
module tb_uart_top;

  localparam int unsigned C        = 868;
  localparam int unsigned HALF_BIT = C / 2;

  logic       i_clk      = 1'b0;
  logic       i_rst_n    = 1'b0;
  logic       i_uart_rxd = 1'b1;
  logic       i_tx_dv    = 1'b0;
  logic [7:0] i_tx_byte  = 8'h00;
  logic       o_tx_done;
  logic [7:0] o_rx_byte;
  logic       o_uart_txd;
  logic       o_rx_dv_led;
  logic       o_tx_active_led;

  uart_top #(
    .CLKS_PER_BIT(C)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_uart_rxd     (i_uart_rxd),
    .i_tx_dv        (i_tx_dv),
    .i_tx_byte      (i_tx_byte),
    .o_tx_done      (o_tx_done),
    .o_rx_byte      (o_rx_byte),
    .o_uart_txd     (o_uart_txd),
    .o_rx_dv_led    (o_rx_dv_led),
    .o_tx_active_led(o_tx_active_led)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int unsigned done_cnt = 0;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    logic       stop_ok;
    logic [7:0] exp_rx;
    logic       exp_led;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int unsigned val,
                             input int unsigned lo, input int unsigned hi);
    n_cmp++;
    if (val < lo || val > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  // Line monitor: decodes frames on o_uart_txd at bit centres and checks them
  // against the TX scoreboard; checks o_rx_byte against the RX scoreboard on
  // each rising edge of o_rx_dv_led; counts o_tx_done pulses.
  logic        mon_act  = 1'b0;
  int unsigned mon_cnt  = 0;
  int unsigned mon_k    = 0;
  logic [9:0]  mon_bits = '0;
  logic [9:0]  mon_exp;
  logic [7:0]  mon_byte;
  logic        prev_txd = 1'b1;
  logic        prev_led = 1'b0;

  always @(negedge i_clk) begin
    if (o_tx_done === 1'b1) done_cnt++;
    if (!i_rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (prev_txd === 1'b1 && o_uart_txd === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt >= HALF_BIT && ((mon_cnt - HALF_BIT) % C) == 0) begin
        mon_k           = (mon_cnt - HALF_BIT) / C;
        mon_bits[mon_k] = o_uart_txd;
        if (mon_k == 9) begin
          mon_act = 1'b0;
          if (tx_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_unexpected_frame: got frame 0x%0h, expected none", mon_bits);
          end else begin
            mon_byte = tx_q.pop_front();
            mon_exp  = {1'b1, mon_byte, 1'b0};
            check("tx_frame", {22'd0, mon_bits}, {22'd0, mon_exp});
          end
        end
      end
    end
    if (i_rst_n && o_rx_dv_led === 1'b1 && prev_led !== 1'b1) begin
      if (rx_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_unexpected_byte: got 0x%0h, expected none", o_rx_byte);
      end else begin
        mon_byte = rx_q.pop_front();
        check("rx_scoreboard", {24'd0, o_rx_byte}, {24'd0, mon_byte});
      end
    end
    prev_txd = o_uart_txd;
    prev_led = o_rx_dv_led;
  end

  // Sends one byte and checks latency, active LED, done timing and width.
  // extra_at (if nonzero) pulses a second i_tx_dv that many cycles in.
  task automatic send_tx(input logic [7:0] b, input int unsigned extra_at,
                         input logic [7:0] extra_b);
    int unsigned s;
    int unsigned d0;
    int unsigned inactive;
    int unsigned delta;
    logic        seen;
    @(negedge i_clk);
    i_tx_byte = b;
    i_tx_dv   = 1'b1;
    tx_q.push_back(b);
    s  = cyc + 1;
    d0 = done_cnt;
    @(negedge i_clk);
    i_tx_dv = 1'b0;
    check("tx_latency_txd", {31'd0, o_uart_txd}, 32'd0);
    check("tx_latency_active", {31'd0, o_tx_active_led}, 32'd1);
    inactive = 0;
    seen     = 1'b0;
    delta    = 0;
    for (int unsigned w = 0; w < 10 * C + 50 && !seen; w++) begin
      if (extra_at != 0 && w == extra_at) begin
        i_tx_byte = extra_b;
        i_tx_dv   = 1'b1;
      end else begin
        i_tx_dv = 1'b0;
      end
      @(negedge i_clk);
      if (o_tx_done === 1'b1) begin
        seen  = 1'b1;
        delta = cyc - s;
      end else if (o_tx_active_led !== 1'b1) begin
        inactive++;
      end
    end
    i_tx_dv = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL tx_done_timeout: got no done pulse, expected one within %0d cycles", 10 * C + 50);
    end else begin
      check("tx_active_throughout", inactive, 0);
      check_range("tx_done_timing", delta, 10 * C - 1, 10 * C + 1);
      @(negedge i_clk);
      check("tx_done_width", {31'd0, o_tx_done}, 32'd0);
      check("tx_idle_txd", {31'd0, o_uart_txd}, 32'd1);
      check("tx_idle_active", {31'd0, o_tx_active_led}, 32'd0);
      @(negedge i_clk);
      check("tx_done_count", done_cnt - d0, 1);
    end
  endtask

  // Drives one frame on the RX pin; a bad stop bit is held low only past its
  // centre so the line is unambiguously idle before the next frame.
  task automatic drive_rx(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) rx_q.push_back(b);
    @(negedge i_clk);
    i_uart_rxd = 1'b0;
    repeat (C) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_uart_rxd = b[i];
      repeat (C) @(negedge i_clk);
    end
    if (stop_ok) begin
      i_uart_rxd = 1'b1;
      repeat (C) @(negedge i_clk);
    end else begin
      i_uart_rxd = 1'b0;
      repeat (HALF_BIT + 20) @(negedge i_clk);
      i_uart_rxd = 1'b1;
      repeat (C - HALF_BIT - 20) @(negedge i_clk);
    end
  endtask

  initial begin : watchdog
    #(2_000_000);
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  int unsigned d_mark;

  initial begin
    vecs[0] = '{tx: 8'hAB, rx: 8'h3F, stop_ok: 1'b1, exp_rx: 8'h3F, exp_led: 1'b1};
    vecs[1] = '{tx: 8'h12, rx: 8'h55, stop_ok: 1'b0, exp_rx: 8'h3F, exp_led: 1'b0};
    vecs[2] = '{tx: 8'hA5, rx: 8'hC3, stop_ok: 1'b1, exp_rx: 8'hC3, exp_led: 1'b1};
    vecs[3] = '{tx: 8'h00, rx: 8'h80, stop_ok: 1'b1, exp_rx: 8'h80, exp_led: 1'b1};

    // Reset values
    i_rst_n = 1'b0;
    repeat (5) @(negedge i_clk);
    check("rst_txd", {31'd0, o_uart_txd}, 32'd1);
    check("rst_done", {31'd0, o_tx_done}, 32'd0);
    check("rst_active", {31'd0, o_tx_active_led}, 32'd0);
    check("rst_rx_byte", {24'd0, o_rx_byte}, 32'h00);
    check("rst_rx_led", {31'd0, o_rx_dv_led}, 32'd0);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);

    // Table: simultaneous TX and RX frames
    for (int unsigned i = 0; i < 4; i++) begin
      fork
        begin
          send_tx(vecs[i].tx, 0, 8'h00);
        end
        begin
          drive_rx(vecs[i].rx, vecs[i].stop_ok);
        end
      join
      @(negedge i_clk);
      check($sformatf("vec%0d_rx_byte", i), {24'd0, o_rx_byte}, {24'd0, vecs[i].exp_rx});
      check($sformatf("vec%0d_rx_led", i), {31'd0, o_rx_dv_led}, {31'd0, vecs[i].exp_led});
    end

    // RX glitch: 100-cycle low pulse is rejected
    @(negedge i_clk);
    i_uart_rxd = 1'b0;
    repeat (100) @(negedge i_clk);
    i_uart_rxd = 1'b1;
    repeat (C) @(negedge i_clk);
    check("glitch_rx_byte", {24'd0, o_rx_byte}, 32'h80);
    check("glitch_rx_led", {31'd0, o_rx_dv_led}, 32'd0);

    // TX busy: mid-frame strobe ignored; RX concurrently proves it left START
    fork
      begin
        send_tx(8'hAB, 5 * C, 8'h12);
      end
      begin
        drive_rx(8'h5A, 1'b1);
      end
    join
    @(negedge i_clk);
    check("busy_rx_byte", {24'd0, o_rx_byte}, 32'h5A);
    check("busy_rx_led", {31'd0, o_rx_dv_led}, 32'd1);

    // Reset during DATA aborts the frame without a done pulse
    @(negedge i_clk);
    i_tx_byte = 8'hAB;
    i_tx_dv   = 1'b1;
    @(negedge i_clk);
    i_tx_dv = 1'b0;
    d_mark  = done_cnt;
    repeat (3 * C) @(negedge i_clk);
    check("pre_rst_active", {31'd0, o_tx_active_led}, 32'd1);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("mid_rst_txd", {31'd0, o_uart_txd}, 32'd1);
    check("mid_rst_active", {31'd0, o_tx_active_led}, 32'd0);
    check("mid_rst_rx_byte", {24'd0, o_rx_byte}, 32'h00);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (8 * C) @(negedge i_clk);
    check("mid_rst_no_done", done_cnt - d_mark, 0);
    check("mid_rst_txd_idle", {31'd0, o_uart_txd}, 32'd1);
    send_tx(8'hA5, 0, 8'h00);

    repeat (10) @(negedge i_clk);
    check("tx_queue_drained", tx_q.size(), 0);
    check("rx_queue_drained", rx_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
